// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the byte-serial ALU sequencer: FSM state encoding,
// ALU select codes and a zero-detect helper.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD_OP = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    EXEC    = 3'd3,
    RESP    = 3'd4
  } state_t;

  // "and"/"or" are reserved words, hence the OP_ prefix
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  function automatic logic is_zero(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Purely combinational 8-bit ALU used by the sequencer; arithmetic wraps
// modulo 256.
module alu_8bits
  import alu_seq_ctrl_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] S,
  output logic [7:0] Result
);

  // Operation select
  always_comb begin
    Result = 8'h00;
    case (S)
      OP_ADD:  Result = a + b;
      OP_SUB:  Result = a - b;
      OP_AND:  Result = a & b;
      OP_OR:   Result = a | b;
      default: Result = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Byte-serial ALU sequencer: collects opcode, A and B over a valid/ready
// stream, computes one result and holds it until downstream accepts.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         op_r;
  logic [7:0]         a_r;
  logic [7:0]         b_r;
  logic [7:0]         out_data_r;
  logic               out_zero_r;
  logic [CNT_W-1:0]   op_count_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic [7:0]         alu_result_s;

  assign in_xfer_s  = in_valid && in_ready_r && ena;
  assign out_xfer_s = out_valid_r && out_ready && ena;

  // ALU sees only latched fields, never the live input byte
  alu_8bits u_alu (
    .a      (a_r),
    .b      (b_r),
    .S      (op_r),
    .Result (alu_result_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD_OP: if (in_xfer_s)  state_s = LOAD_A;  else state_s = state_r;
      LOAD_A:  if (in_xfer_s)  state_s = LOAD_B;  else state_s = state_r;
      LOAD_B:  if (in_xfer_s)  state_s = EXEC;    else state_s = state_r;
      EXEC:    if (ena)        state_s = RESP;    else state_s = state_r;
      RESP:    if (out_xfer_s) state_s = LOAD_OP; else state_s = state_r;
      default: state_s = LOAD_OP;
    endcase
  end

  // State and handshake flags; flags follow the next state so they are
  // registered yet exact, and in_ready stays low through the accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD_OP;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == LOAD_OP) || (state_s == LOAD_A) || (state_s == LOAD_B);
      out_valid_r <= (state_s == RESP);
      busy_r      <= (state_s != LOAD_OP);
    end
  end

  // Frame field capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= 2'b00;
      a_r  <= 8'h00;
      b_r  <= 8'h00;
    end else if (in_xfer_s) begin
      case (state_r)
        LOAD_OP: op_r <= in_data[1:0];
        LOAD_A:  a_r  <= in_data;
        LOAD_B:  b_r  <= in_data;
        default: op_r <= op_r;
      endcase
    end
  end

  // Result register and completed-operation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= 8'h00;
      out_zero_r <= 1'b0;
      op_count_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == EXEC) && ena) begin
        out_data_r <= alu_result_s;
        out_zero_r <= is_zero(alu_result_s);
      end
      if (out_xfer_s) begin
        op_count_r <= op_count_r + CNT_ONE;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_zero  = out_zero_r;
  assign op_count  = op_count_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; a second instance with a 2-bit counter
// shares the stimulus so counter wrap is observed alongside the 8-bit one.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_zero, busy;
  logic [7:0] out_data, op_count;
  logic       in_ready2, out_valid2, out_zero2, busy2;
  logic [7:0] out_data2;
  logic [1:0] op_count2;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .op_count(op_count), .busy(busy)
  );

  alu_seq_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_zero(out_zero2), .op_count(op_count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; one byte transferred on the posedge between
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Called at the negedge just after the B transfer (state EXEC)
  task automatic expect_result(input string tag, input logic [7:0] d, input logic z);
    chk({tag, "_exec_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, z});
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_cnt"}, {24'd0, op_count}, exp_cnt % 256);
    chk({tag, "_cnt2"}, {30'd0, op_count2}, exp_cnt % 4);
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_out_zero"}, {31'd0, out_zero}, 32'd0);
    chk({tag, "_op_count"}, {24'd0, op_count}, 32'd0);
    chk({tag, "_op_count2"}, {30'd0, op_count2}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    chk("rel_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_high", {31'd0, in_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // ADD 0x12+0x34
    send(8'h00); send(8'h12); send(8'h34);
    expect_result("add", 8'h46, 1'b0);
    accept("add");

    // SUB giving zero, then SUB wrapping below zero
    send(8'h01); send(8'h05); send(8'h05);
    expect_result("sub0", 8'h00, 1'b1);
    accept("sub0");
    send(8'h01); send(8'h00); send(8'h01);
    expect_result("subwrap", 8'hFF, 1'b0);
    accept("subwrap");

    // AND with upper opcode bits set, downstream stalls, then ena blocks accept
    send(8'hFE); send(8'hF0); send(8'h3C);
    expect_result("and", 8'h30, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, 32'h30);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_cnt", {24'd0, op_count}, exp_cnt % 256);
    end
    ena = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ena0_valid", {31'd0, out_valid}, 32'd1);
    chk("ena0_cnt", {24'd0, op_count}, exp_cnt % 256);
    ena = 1'b1;
    accept("and");

    // OR with 3-cycle idle gaps between bytes
    send(8'h03);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gapA_busy", {31'd0, busy}, 32'd1);
      chk("gapA_ready", {31'd0, in_ready}, 32'd1);
    end
    send(8'hA0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gapB_ready", {31'd0, in_ready}, 32'd1);
      chk("gapB_valid", {31'd0, out_valid}, 32'd0);
    end
    send(8'h05);
    expect_result("or", 8'hA5, 1'b0);
    accept("or");

    // Reset after A accepted discards the frame and pending count
    send(8'h00); send(8'h12);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h00); send(8'hFF); send(8'h01);
    expect_result("addwrap", 8'h00, 1'b1);
    accept("addwrap");

    // ena low while in EXEC holds the state and the old result
    send(8'h00); send(8'h01); send(8'h01);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exec_hold_valid", {31'd0, out_valid}, 32'd0);
      chk("exec_hold_busy", {31'd0, busy}, 32'd1);
      chk("exec_hold_data", {24'd0, out_data}, 32'h00);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("exec_go_valid", {31'd0, out_valid}, 32'd1);
    chk("exec_go_data", {24'd0, out_data}, 32'h02);
    accept("exec_go");

    // Four back-to-back results after a fresh reset: 2-bit count 1,2,3,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    send(8'h00); send(8'h01); send(8'h02);
    expect_result("b2b1", 8'h03, 1'b0);
    accept("b2b1");
    send(8'h01); send(8'h10); send(8'h01);
    expect_result("b2b2", 8'h0F, 1'b0);
    accept("b2b2");
    send(8'h02); send(8'hFF); send(8'h0F);
    expect_result("b2b3", 8'h0F, 1'b0);
    accept("b2b3");
    send(8'h03); send(8'h80); send(8'h01);
    expect_result("b2b4", 8'h81, 1'b0);
    accept("b2b4");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
